// File: rtl/ar_rx_multi.sv
// ARINC 429 multi-rate receiver.
// Synchronizes and decodes the HI/LO line pair, validates the pulse and null
// widths of each bit cell, assembles 32-bit words, checks odd parity and
// queues the words in a first-word-fall-through FIFO.
module ar_rx_multi #(
  parameter int FCLK     = 50000000,
  parameter int TOL      = 25,
  parameter int DEPTH    = 8,
  parameter int PAR_DROP = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in1,
  input  logic                   in0,
  input  logic [1:0]             mode,
  input  logic                   rx_ready,
  output logic                   rx_valid,
  output logic [31:0]            rx_data,
  output logic                   rx_perr,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   ovf,
  output logic [7:0]             err_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  // Counters must hold the longest interval of interest: the 12.5 kb/s gap.
  localparam int G0_I = 2 * (FCLK / 12500);
  localparam int CW   = $clog2(G0_I + 1) + 1;

  localparam logic [CW-1:0] H0    = CW'((FCLK / 12500) / 2);
  localparam logic [CW-1:0] H1    = CW'((FCLK / 50000) / 2);
  localparam logic [CW-1:0] H2    = CW'((FCLK / 100000) / 2);
  localparam logic [CW-1:0] G0    = CW'(2 * (FCLK / 12500));
  localparam logic [CW-1:0] G1    = CW'(2 * (FCLK / 50000));
  localparam logic [CW-1:0] G2    = CW'(2 * (FCLK / 100000));
  localparam logic [CW-1:0] TOL_C = CW'(TOL);

  typedef enum logic [1:0] {
    S_WAIT_GAP,
    S_IDLE,
    S_PULSE,
    S_NULL
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and line decode
  // ---------------------------------------------------------------------------
  logic [1:0] sync1_reg, sync2_reg;
  logic       sym_hi, sym_lo, sym_null;

  // Two-flop synchronizer for the asynchronous line pair {in1, in0}.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 2'b00;
      sync2_reg <= 2'b00;
    end else begin
      sync1_reg <= {in1, in0};
      sync2_reg <= sync1_reg;
    end
  end

  assign sym_hi   = (sync2_reg == 2'b10);
  assign sym_lo   = (sync2_reg == 2'b01);
  assign sym_null = (sync2_reg == 2'b00);

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [5:0]    bit_cnt_reg, bit_cnt_next;
  logic          bit_val_reg, bit_val_next;
  logic [31:0]   shift_reg, shift_next;
  logic [1:0]    mode_reg, mode_next;

  logic [CW-1:0] h_sel, g_sel, h_min, h_max, cnt_inc;
  logic          width_ok;
  logic          frame_err, word_done;
  logic [31:0]   word_full;
  logic          par_ok;

  // Half-bit width follows the mode latched at word start; the gap length
  // follows the live mode because it decides when the next word may start.
  always_comb begin
    h_sel = H2;
    g_sel = G2;
    case (mode_reg)
      2'd0:    h_sel = H0;
      2'd1:    h_sel = H1;
      default: h_sel = H2;
    endcase
    case (mode)
      2'd0:    g_sel = G0;
      2'd1:    g_sel = G1;
      default: g_sel = G2;
    endcase
  end

  assign h_min     = h_sel - TOL_C;
  assign h_max     = h_sel + TOL_C;
  assign cnt_inc   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
  assign width_ok  = (cnt_reg >= h_min) && (cnt_reg <= h_max);
  assign word_full = {bit_val_reg, shift_reg[31:1]};
  assign par_ok    = ^word_full;

  // State register for the receive FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_WAIT_GAP;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      bit_val_reg <= 1'b0;
      shift_reg   <= '0;
      mode_reg    <= 2'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      bit_val_reg <= bit_val_next;
      shift_reg   <= shift_next;
      mode_reg    <= mode_next;
    end
  end

  // Next-state logic: width checks, bit assembly and framing errors.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    bit_val_next = bit_val_reg;
    shift_next   = shift_reg;
    mode_next    = mode_reg;
    frame_err    = 1'b0;
    word_done    = 1'b0;

    case (state_reg)
      S_WAIT_GAP: begin
        // Any activity (or a disabled receiver) restarts the gap count.
        if (mode == 2'd3 || !sym_null) begin
          cnt_next = '0;
        end else if (cnt_inc >= g_sel) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      S_IDLE: begin
        mode_next = mode;
        cnt_next  = '0;
        if (mode == 2'd3) begin
          state_next = S_WAIT_GAP;
        end else if (sym_hi || sym_lo) begin
          state_next   = S_PULSE;
          cnt_next     = CW'(1);
          bit_cnt_next = '0;
          bit_val_next = sym_hi;
        end
      end

      S_PULSE: begin
        if (sym_null) begin
          if (width_ok) begin
            shift_next   = word_full;
            bit_cnt_next = bit_cnt_reg + 6'd1;
            cnt_next     = CW'(1);
            if (bit_cnt_reg == 6'd31) begin
              word_done  = 1'b1;
              state_next = S_WAIT_GAP;
            end else begin
              state_next = S_NULL;
            end
          end else begin
            frame_err = 1'b1;
          end
        end else if ((sym_hi && bit_val_reg) || (sym_lo && !bit_val_reg)) begin
          // Abort as soon as the pulse outgrows the window.
          if (cnt_reg >= h_max) begin
            frame_err = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          frame_err = 1'b1;
        end
      end

      S_NULL: begin
        if (sym_null) begin
          if (cnt_reg >= h_max) begin
            frame_err = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end else if (sym_hi || sym_lo) begin
          if (width_ok) begin
            state_next   = S_PULSE;
            cnt_next     = CW'(1);
            bit_val_next = sym_hi;
          end else begin
            frame_err = 1'b1;
          end
        end else begin
          frame_err = 1'b1;
        end
      end

      default: state_next = S_WAIT_GAP;
    endcase

    if (frame_err) begin
      state_next = S_WAIT_GAP;
      cnt_next   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Word hand-off and error counter
  // ---------------------------------------------------------------------------
  logic        push_reg;
  logic [31:0] push_data_reg;
  logic        push_perr_reg;
  logic [7:0]  err_cnt_reg;
  logic        err_inc;

  assign err_inc = frame_err || (word_done && !par_ok);

  // Register the completed word for the FIFO; bad-parity words may be dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_reg      <= 1'b0;
      push_data_reg <= '0;
      push_perr_reg <= 1'b0;
    end else begin
      push_reg      <= word_done && (par_ok || (PAR_DROP == 0));
      push_data_reg <= word_full;
      push_perr_reg <= !par_ok;
    end
  end

  // Saturating count of framing and parity errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (err_inc && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [32:0]   head;
  logic          ovf_reg;
  logic          full, pop, wr_en;

  assign full  = (level_reg == LW'(DEPTH));
  assign pop   = rx_valid && rx_ready;
  // When full, a push is only taken if a pop frees a slot in the same cycle.
  assign wr_en = push_reg && (!full || pop);

  // Storage array; {perr, data} per entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= {push_perr_reg, push_data_reg};
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (push_reg && full && !pop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign head     = mem[rd_ptr_reg];
  assign rx_valid = (level_reg != '0);
  assign rx_data  = rx_valid ? head[31:0] : 32'd0;
  assign rx_perr  = rx_valid ? head[32] : 1'b0;
  assign rx_level = level_reg;
  assign ovf      = ovf_reg;

endmodule

// File: doc/ar_rx_multi.md
AR_RX_MULTI -- requirements
Module: ar_rx_multi

Interface
REQ-001 SHALL have parameter FCLK, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter TOL, default 25, allowed +/- deviation of pulse and null widths, in clk cycles.
REQ-003 SHALL have parameter DEPTH, default 8, receive FIFO depth in words; power of two, 2..64.
REQ-004 SHALL have parameter PAR_DROP, default 0; 1 = discard words with bad parity instead of queuing them.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on posedge clk.
REQ-006 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-007 SHALL have port in1, input, 1 bit, ARINC HI line (asynchronous).
REQ-008 SHALL have port in0, input, 1 bit, ARINC LO line (asynchronous).
REQ-009 SHALL have port mode, input, 2 bits, bit rate: 0 = 12.5 kb/s, 1 = 50 kb/s, 2 = 100 kb/s, 3 = disabled.
REQ-010 SHALL have port rx_ready, input, 1 bit, consumer accepts the FIFO head word.
REQ-011 SHALL have port rx_valid, output, 1 bit, FIFO non-empty; head word presented.
REQ-012 SHALL have port rx_data, output, 32 bits, head word; rx_data[n] = n-th bit received (n = 0..31).
REQ-013 SHALL have port rx_perr, output, 1 bit, head word failed odd parity.
REQ-014 SHALL have port rx_level, output, clog2(DEPTH)+1 bits, FIFO occupancy.
REQ-015 SHALL have port ovf, output, 1 bit, sticky FIFO overflow flag.
REQ-016 SHALL have port err_cnt, output, 8 bits, saturating count of framing and parity errors.

Function
REQ-017 SHALL pass in1/in0 through a 2-flop synchronizer and decode the synchronized pair as HI = 10, LO = 01, NULL = 00, ILLEGAL = 11.
REQ-018 SHALL derive Tb = FCLK/rate, half-bit H = Tb/2 and gap G = 2*Tb; cycle counters SHALL be sized for the 12.5 kb/s G.
REQ-019 SHALL accept a pulse or inter-pulse null only if its width in cycles lies in [H-TOL, H+TOL].
REQ-020 SHALL implement FSM states WAIT_GAP, IDLE, PULSE and NULL; rst SHALL enter WAIT_GAP.
REQ-021 In WAIT_GAP: SHALL count consecutive NULL cycles, clear the count on any non-NULL, go to IDLE when the count reaches G, and stay in WAIT_GAP while mode = 3.
REQ-022 In IDLE: SHALL latch mode; on HI or LO SHALL go to PULSE with bit_cnt = 0 and latch the bit value (HI = 1).
REQ-023 In PULSE, on NULL with width valid: SHALL store the bit and increment bit_cnt; if bit_cnt becomes 32 SHALL complete the word and go to WAIT_GAP, else go to NULL.
REQ-024 In PULSE, an invalid width, a direct HI<->LO change or ILLEGAL SHALL be a framing error -> WAIT_GAP.
REQ-025 In NULL: a pulse arriving with a valid null width SHALL go to PULSE; a pulse arriving early, or a null exceeding H+TOL, SHALL be a framing error -> WAIT_GAP.
REQ-026 Pulses after the 32nd bit and before G of NULL SHALL only restart the WAIT_GAP count, with no error.
REQ-027 A mode change mid-word SHALL have no effect until the next IDLE.
REQ-028 On a framing error SHALL discard the partial word and increment err_cnt, saturating at 255.
REQ-029 Parity check: word good iff XOR of all 32 bits = 1; a bad word SHALL increment err_cnt and be pushed with perr = 1, or dropped if PAR_DROP = 1.
REQ-030 A completed word SHALL appear on rx_valid/rx_data 4 clk after the first raw NULL edge ending the 32nd pulse.
REQ-031 FIFO SHALL be first-word fall-through; a pop occurs when rx_valid & rx_ready.
REQ-032 A push when full SHALL drop the new word and set ovf; a simultaneous push and pop when full SHALL accept the push and keep rx_level unchanged.
REQ-033 rx_ready while empty SHALL be ignored; FIFO order SHALL be strictly preserved.

Reset
REQ-034 While rst = 1 at a clk edge: FSM -> WAIT_GAP; bit_cnt, counters and FIFO pointers -> 0; rx_valid = 0, rx_data = 0, rx_perr = 0, rx_level = 0, ovf = 0, err_cnt = 0.
REQ-035 rst mid-word SHALL discard the word without counting an error; reception resumes only after G of NULL.

Verification (FCLK = 50 MHz, TOL = 25)
REQ-036 mode = 2, reset, 1000 NULL cycles, word 0x00000001 with 250/250 cycle cells -> rx_valid = 1 at +4 clk, rx_data = 0x00000001, rx_perr = 0, rx_level = 1.
REQ-037 Word 0x00000003 (even parity) -> rx_perr = 1, err_cnt = 1; with PAR_DROP = 1 -> no push, err_cnt = 1.
REQ-038 Bit 10 pulse of 200 cycles -> no word, err_cnt += 1; next good word after a 1000-cycle gap is received.
REQ-039 rx_ready = 0, 9 good words -> rx_level = 8, ovf = 1; drain -> words 1..8 in order; ovf stays 1.
REQ-040 rst during bit 16 -> all outputs zero; a word starting 100 cycles after rst release is ignored; the word after a 1000-cycle gap is received.
REQ-041 mode = 0, cells of 2000 cycles, gap 8000 -> word received; 1990-cycle cells also accepted; 2030-cycle cells -> framing error.
